data_bus_mailbox: RTL and testbench
===================================

# data_bus_mailbox

Memory-mapped responder on the core's data memory bus, the device end of the bus the core drives, decoded alongside the data memory. It gives the core a byte-wide TX FIFO that an external consumer drains with valid/ready, and an RX FIFO that an external producer fills with valid/ready. The core accesses status, data and control registers with single-cycle loads and stores. Bus reads return data combinationally in the same cycle; every side effect (push, pop, flush, sticky-flag update) commits on the rising clock edge.

## Interface
- BASE_ADDR, 32'h8000_0000: 16-byte-aligned base of the register window.
- DEPTH, 8: entries per FIFO; must be a power of two and ≥2. CW = $clog2(DEPTH)+1.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; no async reset.
- address  in  32  byte address from the core.
- read_enable  in  1  load strobe.
- write_enable  in  1  store strobe.
- byte_enable  in  4  store byte lanes.
- write_data  in  32  store data.
- read_data  out  32  load data, combinational.
- o_tx_data  out  8  head of TX FIFO.
- o_tx_valid  out  1  TX FIFO not empty.
- i_tx_ready  in  1  consumer accepts o_tx_data this cycle.
- i_rx_data  in  8  producer byte.
- i_rx_valid  in  1  producer byte valid.
- o_rx_ready  out  1  RX FIFO not full.
- o_irq  out  1  present only with DATA_BUS_MAILBOX_IRQ_EN.

## Operation
- Select: hit = (address[31:4] == BASE_ADDR[31:4]). Offset = address[3:2]. address[1:0] ignored.
- Offset 0, TXDATA. Store with hit and byte_enable[0] pushes write_data[7:0] if TX is not full. Store while full drops the byte and sets sticky tx_ovf. Load returns 0.
- Offset 1, RXDATA. Load returns {rx_nonempty, 23'b0, rx_head[7:0]}. If RX is nonempty, the load pops RX at the edge. A load while RX is empty returns 0 and sets sticky rx_unf. Stores are ignored.
- Offset 2, STATUS, read-only:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty
  - bit4 tx_ovf, bit5 rx_unf
  - [8+:CW] tx_count, [16+:CW] rx_count
  - all other bits 0.
- Offset 3, CONTROL. Only stores with byte_enable[0] take effect:
  - bit0 flushes TX
  - bit1 flushes RX
  - bit2 clears both sticky flags
  - bit3 irq_en, stored only with IRQ_EN
  - Load returns {28'b0, irq_en, 3'b0}.
- No hit: read_data = 0 and no side effects.
- External TX pop: o_tx_valid & i_tx_ready. External RX push: i_rx_valid & o_rx_ready.
- Full and empty are evaluated from the pre-edge state:
  - A bus push to a full TX in the same cycle as an external pop is dropped and flagged.
  - A bus pop of an empty RX in the same cycle as an external push returns 0 and flags rx_unf. The pushed byte is kept.
- A push and pop on a nonempty, nonfull FIFO in the same cycle leaves the count unchanged.
- Flush has priority over a same-cycle push or pop on that FIFO. After flush, count = 0 and pointers = 0.
- read_enable and write_enable both high: the load returns pre-edge state, and both side effects apply.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are CW bits and range 0..DEPTH.

## Timing
- Reset values: read_data = 0 (comb, no hit), o_tx_valid = 0, o_tx_data = 0, o_rx_ready = 1, o_irq = 0. All counts, pointers, sticky flags and irq_en are 0. Storage contents are don't-care, but o_tx_data is forced to 0 while TX is empty.
- Reset mid-operation discards all FIFO contents in that cycle. Any bus or stream handshake in the reset cycle is ignored.
- Bus latency: 0 cycles for read data; side effects appear on the next cycle.
- Stream latency: a byte pushed at edge N is visible on o_tx_data/o_tx_valid after edge N, and is readable through RXDATA from cycle N+1.
- o_rx_ready and o_tx_valid depend only on registered state and never on same-cycle inputs.

## Configuration
- DATA_BUS_MAILBOX_IRQ_EN defined:
  - o_irq = irq_en & (rx_nonempty | tx_ovf | rx_unf), registered.
  - CONTROL bit3 is writable.
- Undefined:
  - o_irq port absent.
  - CONTROL bit3 reads 0 and ignores writes.
  - No irq register.

## Structure
- Package data_bus_mailbox_pkg holds:
  - register offsets: MBX_TXDATA = 0, MBX_RXDATA = 1, MBX_STATUS = 2, MBX_CONTROL = 3
  - STATUS and CONTROL bit-position constants.
- Sub-module mailbox_fifo (params WIDTH = 8, DEPTH):
  - inputs push, pop, flush; outputs head, full, empty, count.
  - synchronous reset; instantiated twice.
- The top module holds address decode, the read mux, the sticky flags and the irq logic.

## Test plan
- Reset, then load STATUS at BASE+8 → 32'h0000_000A (tx_empty, rx_empty); o_rx_ready = 1, o_tx_valid = 0.
- Store 0x41, 0x42, 0x43 to BASE+0 with i_tx_ready = 0 → tx_count = 3 and o_tx_data = 0x41. Raise i_tx_ready → 0x41, 0x42, 0x43 over 3 cycles, then o_tx_valid = 0.
- Store 9 bytes to TXDATA with DEPTH = 8 and i_tx_ready = 0 → STATUS bit0 = 1 and bit4 = 1, tx_count = 8. The ninth byte never appears. Store CONTROL = 4 → bit4 = 0.
- Drive RX bytes 0x10..0x17 → o_rx_ready = 0 after the eighth. Load RXDATA → 32'h8000_0010 and o_rx_ready = 1 next cycle. A load with RX empty → 0 and rx_unf = 1.
- Same cycle: bus store to a full TX and external pop → byte dropped, tx_ovf = 1, count = 7. Store CONTROL = 3 with both FIFOs nonempty → both counts 0 next cycle.
- IRQ_EN build: store CONTROL = 8, then push one RX byte → o_irq = 1. Pop it → o_irq = 0.

Source files
------------

// File: rtl/data_bus_mailbox_pkg.sv
// Register map and bit positions for the data-bus mailbox.
// No logic; constants only.
// Shared by the top module and the bench-facing documentation of the window.
package data_bus_mailbox_pkg;

   // Word offsets within the 16-byte register window (address[3:2])
   typedef enum logic [1:0] {
      MBX_TXDATA  = 2'd0,
      MBX_RXDATA  = 2'd1,
      MBX_STATUS  = 2'd2,
      MBX_CONTROL = 2'd3
   } mbx_reg_e;

   // STATUS bit positions
   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_UNF   = 5;
   localparam int ST_TX_COUNT = 8;
   localparam int ST_RX_COUNT = 16;

   // CONTROL bit positions
   localparam int CTRL_FLUSH_TX  = 0;
   localparam int CTRL_FLUSH_RX  = 1;
   localparam int CTRL_CLR_STICK = 2;
   localparam int CTRL_IRQ_EN    = 3;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO, DEPTH entries (power of two, >= 2), with flush.
// Latency: a push at edge N is at the head after edge N; head is 0 while empty.
// Backpressure: push ignored when full, pop ignored when empty, both judged pre-edge.
module mailbox_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Flush wins over any same-cycle push or pop
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   // Head is forced to zero when empty so stale storage never leaks out
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; it is only visible through head when nonempty
   always_ff @(posedge clock) begin
      if (do_push && !reset) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/data_bus_mailbox.sv
// Data-bus mailbox: byte TX/RX FIFOs behind a 4-register window; optional irq via DATA_BUS_MAILBOX_IRQ_EN.
// Latency: loads return combinationally; pushes, pops, flushes and flag updates commit at the edge.
// Backpressure: o_tx_valid/o_rx_ready come from registered FIFO state; full-TX stores drop and flag.
module data_bus_mailbox
   import data_bus_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 8,
   localparam int         CW        = $clog2(DEPTH) + 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [3:0]  byte_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready
`ifdef DATA_BUS_MAILBOX_IRQ_EN
   ,
   output logic        o_irq
`endif
);

   logic          hit;
   mbx_reg_e      off;
   logic          tx_wr;
   logic          rx_rd;
   logic          ctrl_wr;
   logic          tx_flush;
   logic          rx_flush;
   logic          clr_sticky;
   logic          tx_pop;
   logic          rx_push;
   logic [7:0]    tx_head;
   logic [7:0]    rx_head;
   logic          tx_full;
   logic          tx_empty;
   logic          rx_full;
   logic          rx_empty;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] rx_count;
   logic          tx_ovf;
   logic          rx_unf;
   logic          irq_en;
   logic [31:0]   status;
   logic [31:0]   control;
   logic          unused;

   // Address decode; the low two byte-address bits are don't-care
   assign hit        = (address[31:4] == BASE_ADDR[31:4]);
   assign off        = mbx_reg_e'(address[3:2]);
   assign tx_wr      = hit & write_enable & byte_enable[0] & (off == MBX_TXDATA);
   assign rx_rd      = hit & read_enable & (off == MBX_RXDATA);
   assign ctrl_wr    = hit & write_enable & byte_enable[0] & (off == MBX_CONTROL);
   assign tx_flush   = ctrl_wr & write_data[CTRL_FLUSH_TX];
   assign rx_flush   = ctrl_wr & write_data[CTRL_FLUSH_RX];
   assign clr_sticky = ctrl_wr & write_data[CTRL_CLR_STICK];

   // Stream handshakes use only registered FIFO state for valid/ready
   assign o_tx_valid = ~tx_empty;
   assign o_tx_data  = tx_head;
   assign o_rx_ready = ~rx_full;
   assign tx_pop     = ~tx_empty & i_tx_ready;
   assign rx_push    = i_rx_valid & ~rx_full;

   mailbox_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (tx_wr),
      .pop   (tx_pop),
      .flush (tx_flush),
      .data  (write_data[7:0]),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   mailbox_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_rd),
      .flush (rx_flush),
      .data  (i_rx_data),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // Sticky error flags; set and clear can never coincide since they need different offsets
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
      end else begin
         if (clr_sticky) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
         end
         if (tx_wr && tx_full)  tx_ovf <= 1'b1;
         if (rx_rd && rx_empty) rx_unf <= 1'b1;
      end
   end

`ifdef DATA_BUS_MAILBOX_IRQ_EN
   // Interrupt enable bit and registered interrupt output
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_en <= 1'b0;
         o_irq  <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en <= write_data[CTRL_IRQ_EN];
         o_irq <= irq_en & (~rx_empty | tx_ovf | rx_unf);
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   // STATUS and CONTROL read words
   always_comb begin
      status                       = '0;
      status[ST_TX_FULL]           = tx_full;
      status[ST_TX_EMPTY]          = tx_empty;
      status[ST_RX_FULL]           = rx_full;
      status[ST_RX_EMPTY]          = rx_empty;
      status[ST_TX_OVF]            = tx_ovf;
      status[ST_RX_UNF]            = rx_unf;
      status[ST_TX_COUNT +: CW]    = tx_count;
      status[ST_RX_COUNT +: CW]    = rx_count;
      control                      = '0;
      control[CTRL_IRQ_EN]         = irq_en;
   end

   // Load data mux; zero unless this window is addressed by a load
   always_comb begin
      read_data = '0;
      if (hit && read_enable) begin
         case (off)
            MBX_TXDATA:  read_data = '0;
            MBX_RXDATA:  read_data = {~rx_empty, 23'b0, rx_head};
            MBX_STATUS:  read_data = status;
            MBX_CONTROL: read_data = control;
            default:     read_data = '0;
         endcase
      end
   end

   assign unused = ^{address[1:0], byte_enable[3:1], write_data[31:8]};

endmodule

// File: tb/tb_data_bus_mailbox.sv
// Directed bench for data_bus_mailbox, DEPTH = 8, BASE = 0x8000_0000.
// Inputs driven on the falling edge; outputs sampled away from the rising edge.
// Build with DATA_BUS_MAILBOX_IRQ_EN to include the interrupt steps.
module tb_data_bus_mailbox;

   localparam logic [31:0] B   = 32'h8000_0000;
   localparam logic [31:0] TXD = B;
   localparam logic [31:0] RXD = B + 32'd4;
   localparam logic [31:0] STS = B + 32'd8;
   localparam logic [31:0] CTL = B + 32'd12;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic        read_enable;
   logic        write_enable;
   logic [3:0]  byte_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        o_rx_ready;
`ifdef DATA_BUS_MAILBOX_IRQ_EN
   logic        o_irq;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] rd;

   always #5 clock = ~clock;

   data_bus_mailbox #(.BASE_ADDR(B), .DEPTH(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .byte_enable  (byte_enable),
      .write_data   (write_data),
      .read_data    (read_data),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_rx_ready   (o_rx_ready)
`ifdef DATA_BUS_MAILBOX_IRQ_EN
      ,
      .o_irq        (o_irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clock);
      address     = a;
      read_enable = 1'b1;
      #1 d = read_data;
      @(posedge clock);
      #1 read_enable = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clock);
      address      = a;
      write_data   = d;
      byte_enable  = be;
      write_enable = 1'b1;
      @(posedge clock);
      #1 write_enable = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] d);
      @(negedge clock);
      i_rx_data  = d;
      i_rx_valid = 1'b1;
      @(negedge clock);
      i_rx_valid = 1'b0;
   endtask

   // Consumer takes n bytes starting at value first, then TX must be empty
   task automatic drain(input string tag, input logic [7:0] first, input int n);
      @(negedge clock);
      i_tx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         check({tag, "_valid"}, {31'b0, o_tx_valid}, 32'd1);
         check({tag, "_data"}, {24'b0, o_tx_data}, {24'b0, 8'(first + 8'(i))});
      end
      @(negedge clock);
      check({tag, "_empty"}, {31'b0, o_tx_valid}, 32'd0);
      i_tx_ready = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      address      = '0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      byte_enable  = 4'h0;
      write_data   = '0;
      i_tx_ready   = 1'b0;
      i_rx_data    = '0;
      i_rx_valid   = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_read_data", read_data, 32'h0);
      check("rst_tx_valid", {31'b0, o_tx_valid}, 32'd0);
      check("rst_tx_data", {24'b0, o_tx_data}, 32'h0);
      check("rst_rx_ready", {31'b0, o_rx_ready}, 32'd1);
`ifdef DATA_BUS_MAILBOX_IRQ_EN
      check("rst_irq", {31'b0, o_irq}, 32'd0);
`endif
      bus_rd(STS, rd);
      check("rst_status", rd, 32'h0000_000A);

      // Three TX bytes held by the consumer, then drained in order
      bus_wr(TXD, 32'h41, 4'h1);
      bus_wr(TXD, 32'h42, 4'h1);
      bus_wr(TXD, 32'h43, 4'h1);
      bus_rd(STS, rd);
      check("tx3_status", rd, 32'h0000_0308);
      check("tx3_head", {24'b0, o_tx_data}, 32'h41);
      drain("tx3", 8'h41, 3);

      // Nine stores into an 8-deep TX: overflow flagged, ninth dropped
      for (int i = 0; i < 9; i++) bus_wr(TXD, 32'h50 + i, 4'h1);
      bus_rd(STS, rd);
      check("ovf_status", rd, 32'h0000_0819);
      bus_wr(CTL, 32'h4, 4'h1);
      bus_rd(STS, rd);
      check("ovf_clear", rd, 32'h0000_0809);

      // Store to full TX in the same cycle as an external pop
      @(negedge clock);
      address      = TXD;
      write_data   = 32'h99;
      byte_enable  = 4'h1;
      write_enable = 1'b1;
      i_tx_ready   = 1'b1;
      @(posedge clock);
      #1 write_enable = 1'b0;
      i_tx_ready = 1'b0;
      bus_rd(STS, rd);
      check("fullpop_status", rd, 32'h0000_0718);
      drain("tx7", 8'h51, 7);
      bus_wr(CTL, 32'h4, 4'h1);

      // Fill RX to eight entries
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check("rx_fill_ready", {31'b0, o_rx_ready}, 32'd1);
         i_rx_data  = 8'(8'h10 + 8'(i));
         i_rx_valid = 1'b1;
      end
      @(negedge clock);
      i_rx_valid = 1'b0;
      check("rx_full_ready", {31'b0, o_rx_ready}, 32'd0);
      bus_rd(STS, rd);
      check("rx_full_status", rd, 32'h0008_0006);
      bus_rd(RXD, rd);
      check("rx_pop0", rd, 32'h8000_0010);
      @(negedge clock);
      check("rx_ready_after_pop", {31'b0, o_rx_ready}, 32'd1);
      for (int i = 1; i < 8; i++) begin
         bus_rd(RXD, rd);
         check("rx_pop", rd, 32'h8000_0010 + i);
      end
      bus_rd(RXD, rd);
      check("rx_empty_load", rd, 32'h0);
      bus_rd(STS, rd);
      check("rx_unf_status", rd, 32'h0000_002A);

      // Load of empty RX in the same cycle as an external push
      bus_wr(CTL, 32'h4, 4'h1);
      @(negedge clock);
      address     = RXD;
      read_enable = 1'b1;
      i_rx_data   = 8'h77;
      i_rx_valid  = 1'b1;
      #1 check("unf_push_load", read_data, 32'h0);
      @(posedge clock);
      #1 read_enable = 1'b0;
      i_rx_valid = 1'b0;
      bus_rd(STS, rd);
      check("unf_push_status", rd, 32'h0001_0022);
      bus_rd(RXD, rd);
      check("unf_push_kept", rd, 32'h8000_0077);
      bus_wr(CTL, 32'h4, 4'h1);

      // Simultaneous push and pop keeps the count, then flush both
      bus_wr(TXD, 32'h61, 4'h1);
      bus_wr(TXD, 32'h62, 4'h1);
      rx_send(8'h33);
      @(negedge clock);
      address      = TXD;
      write_data   = 32'h63;
      byte_enable  = 4'h1;
      write_enable = 1'b1;
      i_tx_ready   = 1'b1;
      @(posedge clock);
      #1 write_enable = 1'b0;
      i_tx_ready = 1'b0;
      bus_rd(STS, rd);
      check("pushpop_status", rd, 32'h0001_0200);
      check("pushpop_head", {24'b0, o_tx_data}, 32'h62);
      bus_wr(CTL, 32'h3, 4'h2);
      bus_rd(STS, rd);
      check("flush_be_ignored", rd, 32'h0001_0200);
      bus_wr(CTL, 32'h3, 4'h1);
      bus_rd(STS, rd);
      check("flush_status", rd, 32'h0000_000A);
      check("flush_tx_valid", {31'b0, o_tx_valid}, 32'd0);
      check("flush_tx_data", {24'b0, o_tx_data}, 32'h0);

      // Out-of-window accesses and ignored lanes
      bus_rd(B + 32'h10, rd);
      check("miss_read", rd, 32'h0);
      bus_wr(B + 32'h10, 32'h55, 4'h1);
      bus_wr(TXD, 32'h56, 4'he);
      bus_rd(STS + 32'd3, rd);
      check("miss_status_alias", rd, 32'h0000_000A);
      bus_rd(CTL, rd);
      check("control_read", rd, 32'h0);
      bus_wr(TXD, 32'h57, 4'h1);
      bus_rd(TXD, rd);
      check("txdata_read", rd, 32'h0);

      // Reset mid-operation discards contents and ignores the reset-cycle push
      rx_send(8'h71);
      @(negedge clock);
      reset      = 1'b1;
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h72;
      @(negedge clock);
      reset      = 1'b0;
      i_rx_valid = 1'b0;
      bus_rd(STS, rd);
      check("midreset_status", rd, 32'h0000_000A);
      check("midreset_tx_valid", {31'b0, o_tx_valid}, 32'd0);

`ifdef DATA_BUS_MAILBOX_IRQ_EN
      // Interrupt follows RX occupancy once enabled
      bus_wr(CTL, 32'h8, 4'h1);
      bus_rd(CTL, rd);
      check("irq_en_read", rd, 32'h8);
      rx_send(8'h44);
      @(negedge clock);
      check("irq_set", {31'b0, o_irq}, 32'd1);
      bus_rd(RXD, rd);
      check("irq_pop", rd, 32'h8000_0044);
      @(negedge clock);
      @(negedge clock);
      check("irq_clear", {31'b0, o_irq}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
